// File: rtl/pipeline_stall_sequencer_if.sv
// Control bundle between the hazard/memory/mul-div sources and the pipeline
// stall sequencer; master drives requests, slave returns enables and strobes.
interface pipeline_stall_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             ld_use_stall;
  logic             br_flush;
  logic             dmem_wait;
  logic             md_start;
  logic             md_done;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_go;
  logic             md_busy;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ld_use_stall, br_flush, dmem_wait, md_start, md_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  md_go, md_busy, md_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ld_use_stall, br_flush, dmem_wait, md_start, md_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output md_go, md_busy, md_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Central 5-stage pipeline control: merges hazard, memory-wait and mul/div
// requests into stage enables and bubble strobes, with perf counters.
module pipeline_stall_sequencer #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  pipeline_stall_sequencer_if.slave  ctl
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  localparam int               TMR_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   md_tmr_q, md_tmr_d;
  logic               md_err_q, md_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_go;
  logic flush_ev;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    md_tmr_d     = md_tmr_q;
    md_err_d     = md_err_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_go        = 1'b0;
    flush_ev     = 1'b0;

    if (rst || ctl.dmem_wait) begin
      // Whole pipe frozen; EX is held so any hazard request re-presents itself.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (state_q == MD_WAIT) begin
      md_tmr_d = md_tmr_q + TMR_W'(1);
      if (ctl.md_done || md_tmr_q == TMR_LAST) begin
        state_d = RUN;
        if (!ctl.md_done) md_err_d = 1'b1;
      end else begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end
    end else if (ctl.md_start) begin
      md_go        = 1'b1;
      md_tmr_d     = '0;
      state_d      = MD_WAIT;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (ctl.br_flush) begin
      // Taken branch wins over load-use: the stalled instruction is wrong-path.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_ev    = 1'b1;
    end else if (ctl.ld_use_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_tmr_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_tmr_q <= md_tmr_d;
      md_err_q <= md_err_d;
      if (!pc_en && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign ctl.pc_en        = pc_en;
  assign ctl.if_id_en     = if_id_en;
  assign ctl.id_ex_en     = id_ex_en;
  assign ctl.ex_mem_en    = ex_mem_en;
  assign ctl.mem_wb_en    = mem_wb_en;
  assign ctl.if_id_flush  = if_id_flush;
  assign ctl.id_ex_flush  = id_ex_flush;
  assign ctl.ex_mem_flush = ex_mem_flush;
  assign ctl.md_go        = md_go;
  assign ctl.md_busy      = (state_q == MD_WAIT);
  assign ctl.md_err       = md_err_q;
  assign ctl.stall_cnt    = stall_cnt_q;
  assign ctl.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Table-driven bench for pipeline_stall_sequencer: control outputs checked per
// cycle against the table, counters/md_err via a scoreboard after each edge.
module tb_pipeline_stall_sequencer;

  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem flush | md_go | md_busy}
  localparam logic [9:0] ZERO   = 10'b00000_000_0_0;
  localparam logic [9:0] ZERO_B = 10'b00000_000_0_1;
  localparam logic [9:0] RUNC   = 10'b11111_000_0_0;
  localparam logic [9:0] LDU    = 10'b00111_010_0_0;
  localparam logic [9:0] BRF    = 10'b11111_110_0_0;
  localparam logic [9:0] GO     = 10'b00011_001_1_0;
  localparam logic [9:0] WAITC  = 10'b00011_001_0_1;
  localparam logic [9:0] REL    = 10'b11111_000_0_1;

  typedef struct {
    string      name;
    logic       rst, ld, br, dw, ms, md;
    logic [9:0] ctl;
    logic       err;
  } vec_t;

  typedef struct {
    string   name;
    int      stall;
    int      flush;
    logic    err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_stall  = 0;
  int   m_flush  = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_stall_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_stall_sequencer #(.MD_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.slave)
  );

  function automatic vec_t mk(string name, logic r, logic ld, logic br, logic dw,
                              logic ms, logic md, logic [9:0] c, logic e);
    vec_t v;
    v.name = name; v.rst = r; v.ld = ld; v.br = br; v.dw = dw;
    v.ms = ms; v.md = md; v.ctl = c; v.err = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    logic [9:0] got;
    @(negedge clk);
    rst = v.rst;
    bus.ld_use_stall = v.ld; bus.br_flush = v.br; bus.dmem_wait = v.dw;
    bus.md_start = v.ms;     bus.md_done = v.md;
    #1;
    got = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
           bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.md_go, bus.md_busy};
    check({v.name, "/ctl"}, 32'(got), 32'(v.ctl));
    // Counter model: pc_en low counts a stall, an if_id flush counts a taken branch.
    if (v.rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!v.ctl[9] && m_stall < CNT_SAT) m_stall++;
      if (v.ctl[4] && m_flush < CNT_SAT) m_flush++;
    end
    e.name = v.name; e.stall = m_stall; e.flush = m_flush; e.err = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, "/stall_cnt"}, 32'(bus.stall_cnt), 32'(e.stall));
    check({e.name, "/flush_cnt"}, 32'(bus.flush_cnt), 32'(e.flush));
    check({e.name, "/md_err"},    32'(bus.md_err),    32'(e.err));
  endtask

  initial begin
    rst = 1'b1;
    bus.ld_use_stall = 1'b0; bus.br_flush = 1'b0; bus.dmem_wait = 1'b0;
    bus.md_start = 1'b0;     bus.md_done = 1'b0;
    repeat (2) @(posedge clk);

    //                 name          rst ld br dw ms md  ctl     err
    tbl.push_back(mk("reset0",     1, 0, 0, 0, 0, 0, ZERO,   0));
    tbl.push_back(mk("reset1",     1, 1, 1, 0, 1, 0, ZERO,   0));
    tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, RUNC,   0));
    tbl.push_back(mk("ld_use",     0, 1, 0, 0, 0, 0, LDU,    0));
    tbl.push_back(mk("idle2",      0, 0, 0, 0, 0, 0, RUNC,   0));
    tbl.push_back(mk("reset2",     1, 0, 0, 0, 0, 0, ZERO,   0));
    tbl.push_back(mk("br_over_ld", 0, 1, 1, 0, 0, 0, BRF,    0));
    tbl.push_back(mk("md_go",      0, 0, 0, 0, 1, 0, GO,     0));
    tbl.push_back(mk("md_w1",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("md_w2_br",   0, 0, 1, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("md_w3",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("md_w4",      0, 1, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("md_done",    0, 0, 0, 0, 0, 1, REL,    0));
    tbl.push_back(mk("md_after",   0, 0, 0, 0, 0, 0, RUNC,   0));
    tbl.push_back(mk("to_go",      0, 0, 0, 0, 1, 0, GO,     0));
    tbl.push_back(mk("to_w0",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_w1",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_w2",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_dw0",     0, 0, 0, 1, 1, 0, ZERO_B, 0));
    tbl.push_back(mk("to_dw1",     0, 0, 0, 1, 1, 0, ZERO_B, 0));
    tbl.push_back(mk("to_w3",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_w4",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_w5",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_w6",      0, 0, 0, 0, 1, 0, WAITC,  0));
    tbl.push_back(mk("to_expire",  0, 0, 0, 0, 1, 0, REL,    1));
    tbl.push_back(mk("err_sticky", 0, 0, 0, 0, 0, 0, RUNC,   1));
    tbl.push_back(mk("dw_over_br", 0, 1, 1, 1, 0, 0, ZERO,   1));
    tbl.push_back(mk("done_in_run",0, 0, 0, 0, 0, 1, RUNC,   1));
    tbl.push_back(mk("ms_over_br", 0, 0, 1, 0, 1, 0, GO,     1));
    tbl.push_back(mk("rst_in_wait",1, 0, 0, 0, 1, 0, ZERO_B, 0));
    tbl.push_back(mk("post_rst",   0, 0, 0, 0, 0, 0, RUNC,   0));
    tbl.push_back(mk("no_reissue", 0, 0, 0, 0, 0, 0, RUNC,   0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Multi-cycle corner: both counters pinned at their saturation value.
    for (int i = 0; i < CNT_SAT + 3; i++) apply(mk("stall_sat", 0, 0, 0, 1, 0, 0, ZERO, 0));
    for (int i = 0; i < CNT_SAT + 3; i++) apply(mk("flush_sat", 0, 0, 1, 0, 0, 0, BRF,  0));
    check("stall_held_max", 32'(bus.stall_cnt), 32'(CNT_SAT));
    check("flush_held_max", 32'(bus.flush_cnt), 32'(CNT_SAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
